// File: rtl/uart_cmd_sched_if.sv
// uart_cmd_sched_if: command, register-bus and response signals of the UART command scheduler.
// master = command source / bus target / TX formatter side, slave = scheduler.
interface uart_cmd_sched_if;
    logic        CMD_R;
    logic        CMD_W;
    logic        CMD_FAIL;
    logic        CMD_DONE;
    logic [15:0] CMD_ADDR;
    logic [63:0] CMD_DATA;
    logic        BUS_REQ;
    logic        BUS_WE;
    logic [7:0]  BUS_ADDR;
    logic [31:0] BUS_WDATA;
    logic        BUS_ACK;
    logic [31:0] BUS_RDATA;
    logic        RSP_VALID;
    logic        RSP_READY;
    logic [1:0]  RSP_CODE;
    logic [31:0] RSP_DATA;
    logic        DROP;
    logic [7:0]  DROP_CNT;

    modport master (
        output CMD_R, CMD_W, CMD_FAIL, CMD_DONE, CMD_ADDR, CMD_DATA, BUS_ACK, BUS_RDATA, RSP_READY,
        input  BUS_REQ, BUS_WE, BUS_ADDR, BUS_WDATA, RSP_VALID, RSP_CODE, RSP_DATA, DROP, DROP_CNT
    );

    modport slave (
        input  CMD_R, CMD_W, CMD_FAIL, CMD_DONE, CMD_ADDR, CMD_DATA, BUS_ACK, BUS_RDATA, RSP_READY,
        output BUS_REQ, BUS_WE, BUS_ADDR, BUS_WDATA, RSP_VALID, RSP_CODE, RSP_DATA, DROP, DROP_CNT
    );
endinterface

// File: rtl/uart_cmd_sched.sv
// uart_cmd_sched: turns parsed ASCII-hex UART commands into single register-bus transactions.
// Define UART_CMD_TIMEOUT_EN to build the bus ack timeout (response code 11).
module uart_cmd_sched #(
    parameter int unsigned TIMEOUT = 255
) (
    input logic            CLK,
    input logic            RST,
    uart_cmd_sched_if.slave b
);
    typedef enum logic [1:0] {IDLE, DECODE, BUS, RESP} state_t;

    state_t      state;
    logic        lat_r;
    logic        lat_w;
    logic        lat_fail;
    logic [15:0] lat_addr;
    logic [63:0] lat_data;
`ifdef UART_CMD_TIMEOUT_EN
    logic [15:0] tmo_cnt;
`endif

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("uart_cmd_sched: TIMEOUT must be 1..65535");
    end

    // Characters are pre-validated, so only the low nibble of c - 8'h37 matters.
    function automatic logic [3:0] nib(input logic [7:0] c);
        return (c <= 8'h39) ? c[3:0] : c[3:0] + 4'd9;
    endfunction

    function automatic logic [31:0] hex32(input logic [63:0] d);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[i*4 +: 4] = nib(d[i*8 +: 8]);
        return r;
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            lat_r       <= 1'b0;
            lat_w       <= 1'b0;
            lat_fail    <= 1'b0;
            lat_addr    <= '0;
            lat_data    <= '0;
            b.BUS_REQ   <= 1'b0;
            b.BUS_WE    <= 1'b0;
            b.BUS_ADDR  <= '0;
            b.BUS_WDATA <= '0;
            b.RSP_VALID <= 1'b0;
            b.RSP_CODE  <= '0;
            b.RSP_DATA  <= '0;
            b.DROP      <= 1'b0;
            b.DROP_CNT  <= '0;
`ifdef UART_CMD_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
        end else begin
            b.DROP <= b.CMD_DONE && state != IDLE;
            if (b.CMD_DONE && state != IDLE && b.DROP_CNT != 8'hFF)
                b.DROP_CNT <= b.DROP_CNT + 8'd1;
            case (state)
                IDLE: if (b.CMD_DONE) begin
                    lat_r    <= b.CMD_R;
                    lat_w    <= b.CMD_W;
                    lat_fail <= b.CMD_FAIL;
                    lat_addr <= b.CMD_ADDR;
                    lat_data <= b.CMD_DATA;
                    state    <= DECODE;
                end
                DECODE: if (lat_fail || lat_r == lat_w) begin
                    b.RSP_CODE  <= 2'b10;
                    b.RSP_DATA  <= '0;
                    b.RSP_VALID <= 1'b1;
                    state       <= RESP;
                end else begin
                    b.BUS_WE    <= lat_w;
                    b.BUS_ADDR  <= {nib(lat_addr[15:8]), nib(lat_addr[7:0])};
                    b.BUS_WDATA <= hex32(lat_data);
                    b.BUS_REQ   <= 1'b1;
`ifdef UART_CMD_TIMEOUT_EN
                    tmo_cnt     <= '0;
`endif
                    state       <= BUS;
                end
                BUS: if (b.BUS_ACK) begin
                    b.BUS_REQ   <= 1'b0;
                    b.RSP_CODE  <= b.BUS_WE ? 2'b00 : 2'b01;
                    b.RSP_DATA  <= b.BUS_WE ? 32'h0 : b.BUS_RDATA;
                    b.RSP_VALID <= 1'b1;
                    state       <= RESP;
`ifdef UART_CMD_TIMEOUT_EN
                end else if (tmo_cnt == 16'(TIMEOUT - 1)) begin
                    b.BUS_REQ   <= 1'b0;
                    b.RSP_CODE  <= 2'b11;
                    b.RSP_DATA  <= '0;
                    b.RSP_VALID <= 1'b1;
                    state       <= RESP;
                end else begin
                    tmo_cnt <= tmo_cnt + 16'd1;
`endif
                end
                RESP: if (b.RSP_READY) begin
                    b.RSP_VALID <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_cmd_sched.sv
// tb_uart_cmd_sched: scoreboard bench; expected bus requests and responses are queued by the
// stimulus and popped by a negedge monitor. Timeout checks apply when UART_CMD_TIMEOUT_EN is defined.
module tb_uart_cmd_sched;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    uart_cmd_sched_if bif();
    uart_cmd_sched #(.TIMEOUT(4)) dut (.CLK(CLK), .RST(RST), .b(bif.slave));

    typedef struct {logic we; logic [7:0] addr; logic [31:0] wdata;} bus_t;
    typedef struct {logic [1:0] code; logic [31:0] data;} rsp_t;

    bus_t bq[$];
    rsp_t rq[$];
    bus_t eb, last_bus;
    rsp_t er;
    int   n_chk = 0;
    int   n_fail = 0;
    int   drop_seen = 0;
    logic req_q = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (bif.DROP) drop_seen++;
        if (!RST && bif.BUS_REQ) begin
            if (!req_q) begin
                if (bq.size() == 0) chk("bus_unexpected_req", 1, 0);
                else begin
                    eb = bq.pop_front();
                    chk("bus_we", bif.BUS_WE, eb.we);
                    chk("bus_addr", bif.BUS_ADDR, eb.addr);
                    chk("bus_wdata", bif.BUS_WDATA, eb.wdata);
                end
            end else
                chk("bus_hold", {bif.BUS_WE, bif.BUS_ADDR, bif.BUS_WDATA},
                    {last_bus.we, last_bus.addr, last_bus.wdata});
            last_bus = '{bif.BUS_WE, bif.BUS_ADDR, bif.BUS_WDATA};
        end
        req_q = bif.BUS_REQ;
        if (!RST && bif.RSP_VALID && bif.RSP_READY) begin
            if (rq.size() == 0) chk("rsp_unexpected", 1, 0);
            else begin
                er = rq.pop_front();
                chk("rsp_code", bif.RSP_CODE, er.code);
                chk("rsp_data", bif.RSP_DATA, er.data);
            end
        end
    end

    // CMD_DONE is sampled on the second posedge inside this task (edge T); returns at T+#1.
    task automatic cmd(input logic r, input logic w, input logic f,
                       input logic [15:0] a, input logic [63:0] d);
        @(posedge CLK); #1;
        bif.CMD_R = r; bif.CMD_W = w; bif.CMD_FAIL = f;
        bif.CMD_ADDR = a; bif.CMD_DATA = d; bif.CMD_DONE = 1'b1;
        @(posedge CLK); #1;
        bif.CMD_DONE = 1'b0; bif.CMD_R = 1'b0; bif.CMD_W = 1'b0; bif.CMD_FAIL = 1'b0;
    endtask

    // ACK is sampled on the n-th posedge after the call.
    task automatic ack_at(input int n, input logic [31:0] rd);
        repeat (n - 1) @(posedge CLK);
        #1 bif.BUS_ACK = 1'b1; bif.BUS_RDATA = rd;
        @(posedge CLK); #1;
        bif.BUS_ACK = 1'b0; bif.BUS_RDATA = '0;
    endtask

    task automatic settle();
        int k = 0;
        while ((bif.BUS_REQ || bif.RSP_VALID) && k < 50) begin
            @(posedge CLK); #1;
            k++;
        end
        chk("settle_bound", k < 50, 1);
        repeat (2) @(posedge CLK);
    endtask

    task automatic run_cmd(input logic r, input logic w, input logic [15:0] a,
                           input logic [63:0] d, input int n, input logic [31:0] rd);
        cmd(r, w, 1'b0, a, d);
        @(negedge CLK);
        @(negedge CLK);
        ack_at(n, rd);
        settle();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        bif.CMD_R = 0; bif.CMD_W = 0; bif.CMD_FAIL = 0; bif.CMD_DONE = 0;
        bif.CMD_ADDR = '0; bif.CMD_DATA = '0;
        bif.BUS_ACK = 0; bif.BUS_RDATA = '0; bif.RSP_READY = 1'b1;
        repeat (2) @(posedge CLK); #1;
        chk("rst_req", bif.BUS_REQ, 0);
        chk("rst_valid", bif.RSP_VALID, 0);
        chk("rst_drop_cnt", bif.DROP_CNT, 0);
        chk("rst_outs", {bif.BUS_WE, bif.BUS_ADDR, bif.BUS_WDATA, bif.RSP_CODE, bif.DROP}, 0);
        RST = 1'b0;
        repeat (2) @(posedge CLK);

        // write with latency and one-cycle response checks
        bq.push_back('{1'b1, 8'h1A, 32'hDEADBEEF});
        rq.push_back('{2'b00, 32'h0});
        cmd(0, 1, 0, "1A", "DEADBEEF");
        @(negedge CLK); chk("wr_req_after_T", bif.BUS_REQ, 0);
        @(negedge CLK); chk("wr_req_after_T1", bif.BUS_REQ, 1);
        ack_at(3, 32'hCAFEF00D);
        @(negedge CLK);
        chk("wr_req_after_ack", bif.BUS_REQ, 0);
        chk("wr_valid_after_ack", bif.RSP_VALID, 1);
        @(negedge CLK); chk("wr_valid_one_cycle", bif.RSP_VALID, 0);
        settle();

        // read
        bq.push_back('{1'b0, 8'hF0, 32'h0});
        rq.push_back('{2'b01, 32'h12345678});
        run_cmd(1, 0, "F0", "00000000", 2, 32'h12345678);

        // hex boundary characters 0/9/A/F
        bq.push_back('{1'b1, 8'h9A, 32'h0189ABEF});
        rq.push_back('{2'b00, 32'h0});
        run_cmd(0, 1, "9A", "0189ABEF", 1, 32'h0);

        // parse fail and illegal r/w combinations
        rq.push_back('{2'b10, 32'h0});
        cmd(0, 0, 1, "11", "11111111");
        @(negedge CLK); chk("fail_valid_after_T", bif.RSP_VALID, 0);
        @(negedge CLK);
        chk("fail_valid_after_T1", bif.RSP_VALID, 1);
        chk("fail_no_req", bif.BUS_REQ, 0);
        settle();
        rq.push_back('{2'b10, 32'h0});
        cmd(1, 1, 0, "22", "22222222");
        settle();
        rq.push_back('{2'b10, 32'h0});
        cmd(0, 0, 0, "33", "33333333");
        settle();
        rq.push_back('{2'b10, 32'h0});
        cmd(0, 1, 1, "44", "44444444");
        settle();

`ifdef UART_CMD_TIMEOUT_EN
        bq.push_back('{1'b0, 8'h05, 32'h0});
        rq.push_back('{2'b11, 32'h0});
        cmd(1, 0, 0, "05", "00000000");
        @(negedge CLK);
        cnt = 0;
        repeat (12) begin
            @(negedge CLK);
            if (bif.BUS_REQ) cnt++;
        end
        chk("tmo_req_cycles", cnt, 4);
        settle();
`endif

        // ACK on the 4th BUS edge wins over the timeout
        bq.push_back('{1'b0, 8'h06, 32'h0});
        rq.push_back('{2'b01, 32'h55AA00FF});
        run_cmd(1, 0, "06", "00000000", 4, 32'h55AA00FF);

        // busy drops in BUS and RESP
        drop_seen = 0;
        bq.push_back('{1'b1, 8'h20, 32'h00000001});
        rq.push_back('{2'b00, 32'h0});
        cmd(0, 1, 0, "20", "00000001");
        @(negedge CLK);
        @(negedge CLK);
        cmd(1, 0, 0, "77", "00000000");
        bif.RSP_READY = 1'b0;
        ack_at(1, 32'h0);
        cmd(1, 0, 0, "88", "00000000");
        repeat (10) @(posedge CLK);
        #1;
        chk("drop_valid_held", bif.RSP_VALID, 1);
        chk("drop_pulses", drop_seen, 2);
        chk("drop_cnt_2", bif.DROP_CNT, 2);
        bif.RSP_READY = 1'b1;
        settle();

        // drop counter saturation while parked in RESP
        bq.push_back('{1'b0, 8'h01, 32'h0});
        rq.push_back('{2'b01, 32'hA5A5A5A5});
        bif.RSP_READY = 1'b0;
        cmd(1, 0, 0, "01", "00000000");
        @(negedge CLK);
        @(negedge CLK);
        ack_at(1, 32'hA5A5A5A5);
        bif.CMD_DONE = 1'b1;
        repeat (300) @(posedge CLK);
        #1 bif.CMD_DONE = 1'b0;
        @(posedge CLK); #1;
        chk("drop_cnt_sat", bif.DROP_CNT, 255);
        chk("drop_pulses_sat", drop_seen, 302);
        chk("sat_valid_held", bif.RSP_VALID, 1);
        bif.RSP_READY = 1'b1;
        settle();

        // asynchronous reset mid-transaction
        bq.push_back('{1'b1, 8'h3C, 32'h0000BEEF});
        cmd(0, 1, 0, "3C", "0000BEEF");
        @(negedge CLK);
        @(negedge CLK);
        @(posedge CLK); #2 RST = 1'b1;
        #1;
        chk("arst_req", bif.BUS_REQ, 0);
        chk("arst_valid", bif.RSP_VALID, 0);
        chk("arst_drop_cnt", bif.DROP_CNT, 0);
        chk("arst_outs", {bif.BUS_WE, bif.BUS_ADDR, bif.BUS_WDATA, bif.RSP_CODE, bif.RSP_DATA, bif.DROP}, 0);
        @(posedge CLK); #1 RST = 1'b0;
        repeat (2) @(posedge CLK);
        bq.push_back('{1'b1, 8'hC3, 32'h5A5A0F0F});
        rq.push_back('{2'b00, 32'h0});
        run_cmd(0, 1, "C3", "5A5A0F0F", 2, 32'h0);

        chk("bus_queue_empty", bq.size(), 0);
        chk("rsp_queue_empty", rq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_cmd_sched.md
# uart_cmd_sched

Command scheduler between the UART protocol receiver and the on-chip register bus. It takes each parsed command (read, write or fail), converts the ASCII-hex address and data to binary, and runs exactly one register-bus transaction per command using a req/ack handshake. It then returns a one-entry response to the UART transmit formatter. Commands that arrive while it is busy are dropped and counted.

## Interface
- TIMEOUT, 255: maximum bus cycles to wait for BUS_ACK; legal range 1..65535.
- CLK  in  1  clock.
- RST  in  1  reset; asynchronous, active-high.
- CMD_R  in  1  parsed read command; qualified by CMD_DONE.
- CMD_W  in  1  parsed write command; qualified by CMD_DONE.
- CMD_ADDR  in  16  two ASCII hex characters, MSB character in [15:8].
- CMD_DATA  in  64  eight ASCII hex characters, MSB character in [63:56].
- CMD_FAIL  in  1  parse failure; qualified by CMD_DONE.
- CMD_DONE  in  1  one-cycle command strobe.
- BUS_REQ  out  1  bus request; held until ACK or timeout.
- BUS_WE  out  1  1 = write, 0 = read.
- BUS_ADDR  out  8  binary address.
- BUS_WDATA  out  32  binary write data.
- BUS_ACK  in  1  bus completion.
- BUS_RDATA  in  32  read data; valid when BUS_ACK=1.
- RSP_VALID  out  1  response valid; held until RSP_READY.
- RSP_READY  in  1  TX formatter accepts the response.
- RSP_CODE  out  2  00 write OK, 01 read OK, 10 parse or command error, 11 bus timeout.
- RSP_DATA  out  32  read data when code is 01; 0 otherwise.
- DROP  out  1  one-cycle pulse when a command is dropped.
- DROP_CNT  out  8  saturating count of dropped commands.

## Operation
- States: IDLE, DECODE, BUS, RESP.
- IDLE: if CMD_DONE=1, latch CMD_* and go to DECODE.
- DECODE (always 1 cycle): convert each character. If c <= 8'h39 the nibble is c-8'h30, otherwise c-8'h37. Validity is already guaranteed upstream.
  - CMD_FAIL=1, both CMD_R and CMD_W set, or neither set: go to RESP with code 10 and data 0.
  - Otherwise: load BUS_WE, BUS_ADDR and BUS_WDATA, assert BUS_REQ, go to BUS.
- BUS:
  - If BUS_ACK is sampled high: drop BUS_REQ, set code 01 (capture BUS_RDATA) or 00, go to RESP.
  - If no ACK by timeout: drop BUS_REQ, set code 11, data 0, go to RESP.
- RESP: RSP_VALID=1. On the edge where RSP_VALID and RSP_READY are both 1, clear RSP_VALID and go to IDLE.
- Drops: CMD_DONE=1 in any state other than IDLE gives a DROP pulse and DROP_CNT+1 (saturating at 255). The held command and the state machine are unaffected.
- BUS_WE, BUS_ADDR and BUS_WDATA are stable for the whole time BUS_REQ is high.
- RSP_CODE and RSP_DATA are stable for the whole time RSP_VALID is high.
- Reset values: all outputs 0, state IDLE, DROP_CNT 0, timeout counter 0.

## Timing
- CMD_DONE is sampled at edge T. BUS_REQ (or RSP_VALID for an error command) is high after edge T+1.
- BUS_ACK sampled at edge A: BUS_REQ low and RSP_VALID high after A.
- Timeout: a 16-bit counter is cleared on entering BUS and increments on each BUS edge without ACK.
  - Timeout fires on the edge where the counter equals TIMEOUT-1 and ACK=0, i.e. after exactly TIMEOUT unacknowledged edges.
  - If ACK is sampled on that same edge, ACK wins.
- RSP_READY may already be high on entry to RESP: RSP_VALID then lasts exactly 1 cycle.
- CMD_DONE on the RSP handshake edge: the command is dropped. The block is IDLE only from the following edge.
- RST mid-transaction: BUS_REQ and RSP_VALID drop immediately and the pending command is lost.

## Configuration
- UART_CMD_TIMEOUT_EN:
  - Defined: the timeout counter and response code 11 exist, as specified above.
  - Undefined: the counter is not built, BUS waits for BUS_ACK indefinitely, code 11 is never produced, and TIMEOUT is ignored.

## Test plan
- Write: CMD_W=1, CMD_ADDR="1A", CMD_DATA="DEADBEEF", CMD_DONE, ACK after 3 cycles.
  - Expect BUS_REQ 2 cycles after CMD_DONE with WE=1, ADDR=8'h1A, WDATA=32'hDEADBEEF.
  - Expect RSP code 00, data 0.
- Read: CMD_R=1, CMD_ADDR="F0", ACK with RDATA=32'h12345678.
  - Expect WE=0, ADDR=8'hF0.
  - Expect RSP code 01, data 32'h12345678.
- Parse fail: CMD_FAIL=1 with CMD_DONE.
  - Expect no BUS_REQ; RSP_VALID at T+1 with code 10.
- Timeout (macro defined, TIMEOUT=4): BUS_ACK held low.
  - Expect BUS_REQ high for exactly 4 cycles, then code 11.
  - Repeat with ACK arriving on the 4th edge: expect code 00 or 01.
- Busy drop: second CMD_DONE while in BUS, then RSP_READY held low for 10 cycles with another CMD_DONE.
  - Expect 2 DROP pulses, DROP_CNT=2, and first response intact.
  - Also saturation: 300 drops give DROP_CNT=255.
- Reset: RST asserted while BUS_REQ=1.
  - Expect all outputs 0 asynchronously; the next write command completes normally.
